// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: state enum, stage-control bundle
// and the condition-to-control mapping.
package hazard_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hazard_state_t;

    // Winning hazard condition for the current cycle, highest priority first.
    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_MEMW = 3'd1,
        C_MDW  = 3'd2,
        C_BR   = 3'd3,
        C_LU   = 3'd4,
        C_IMW  = 3'd5
    } hazard_cond_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } stage_ctl_t;

    function automatic stage_ctl_t ctl_for(input hazard_cond_t cond);
        stage_ctl_t c;
        c = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
              mem_wb_en: 1'b1, default: 1'b0};
        case (cond)
            C_MEMW: begin
                c.pc_en        = 1'b0;
                c.if_id_en     = 1'b0;
                c.id_ex_en     = 1'b0;
                c.ex_mem_en    = 1'b0;
                c.mem_wb_flush = 1'b1;
            end
            C_MDW: begin
                c.pc_en        = 1'b0;
                c.if_id_en     = 1'b0;
                c.id_ex_en     = 1'b0;
                c.ex_mem_flush = 1'b1;
            end
            C_BR: begin
                c.if_id_flush  = 1'b1;
                c.id_ex_flush  = 1'b1;
            end
            C_LU: begin
                c.pc_en        = 1'b0;
                c.if_id_en     = 1'b0;
                c.id_ex_flush  = 1'b1;
            end
            C_IMW: begin
                c.pc_en        = 1'b0;
                c.if_id_flush  = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: owns every stage-register enable/flush,
// tracks multi-cycle mul/div occupancy of EX and keeps stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 8,
    parameter int unsigned CNT_W   = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  regbits_t      id_rs1,
    input  regbits_t      id_rs2,
    input  logic          id_use_rs1,
    input  logic          id_use_rs2,
    input  regbits_t      id_ex_rd,
    input  logic          id_ex_RegWr,
    input  logic          id_ex_MemRead,
    input  logic          id_ex_muldiv,
    input  logic          id_ex_isdiv,
    input  logic          ex_branch_taken,
    input  logic          ex_mem_dREN,
    input  logic          ex_mem_dWEN,
    input  logic          dhit,
    input  logic          ihit,
    output logic          pc_en,
    output logic          if_id_en,
    output logic          id_ex_en,
    output logic          ex_mem_en,
    output logic          mem_wb_en,
    output logic          if_id_flush,
    output logic          id_ex_flush,
    output logic          ex_mem_flush,
    output logic          mem_wb_flush,
    output hazard_state_t state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned MD_W    = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
    localparam logic        MUL_MULTI = (MUL_LAT > 1);
    localparam logic        DIV_MULTI = (DIV_LAT > 1);
    // Counter preload: the first EX cycle is spent in RUN, the last with md_cnt==0.
    localparam logic [MD_W-1:0] MUL_INIT = MUL_MULTI ? MD_W'(MUL_LAT - 2) : '0;
    localparam logic [MD_W-1:0] DIV_INIT = DIV_MULTI ? MD_W'(DIV_LAT - 2) : '0;

    logic [MD_W-1:0] md_cnt;
    logic            memw;
    logic            md_start;
    logic            mdw;
    logic            lu;
    hazard_cond_t    cond;
    stage_ctl_t      ctl;

    // Hazard detection and priority resolution.
    always_comb begin
        memw     = (ex_mem_dREN | ex_mem_dWEN) & ~dhit;
        md_start = (state == RUN) & id_ex_muldiv & (id_ex_isdiv ? DIV_MULTI : MUL_MULTI);
        mdw      = ((state == MD_WAIT) & (md_cnt != '0)) | md_start;
        lu       = id_ex_MemRead & id_ex_RegWr & (id_ex_rd != '0)
                 & ((id_use_rs1 & (id_rs1 == id_ex_rd)) | (id_use_rs2 & (id_rs2 == id_ex_rd)));
        cond = C_NONE;
        if (memw) begin
            cond = C_MEMW;
        end else if (mdw) begin
            cond = C_MDW;
        end else if (ex_branch_taken) begin
            cond = C_BR;
        end else if (lu) begin
            cond = C_LU;
        end else if (!ihit) begin
            cond = C_IMW;
        end
        ctl = RST ? ctl_for(C_NONE) : ctl_for(cond);
    end

    assign pc_en        = ctl.pc_en;
    assign if_id_en     = ctl.if_id_en;
    assign id_ex_en     = ctl.id_ex_en;
    assign ex_mem_en    = ctl.ex_mem_en;
    assign mem_wb_en    = ctl.mem_wb_en;
    assign if_id_flush  = ctl.if_id_flush;
    assign id_ex_flush  = ctl.id_ex_flush;
    assign ex_mem_flush = ctl.ex_mem_flush;
    assign mem_wb_flush = ctl.mem_wb_flush;

    // Mul/div occupancy FSM; the unit keeps counting even while a dcache miss freezes EX.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (md_start) begin
                        state  <= MD_WAIT;
                        md_cnt <= id_ex_isdiv ? DIV_INIT : MUL_INIT;
                    end
                end
                MD_WAIT: begin
                    if (md_cnt != '0) begin
                        md_cnt <= md_cnt - MD_W'(1);
                    end else if (!memw) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state  <= RUN;
                    md_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .clr   (RST),
        .inc   (~ctl.pc_en),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .clr   (RST),
        .inc   (ctl.if_id_flush | ctl.id_ex_flush | ctl.ex_mem_flush | ctl.mem_wb_flush),
        .count (flush_count)
    );

endmodule
